// File: rtl/board_input_pkg.sv
// Shared types and defaults for the board input conditioner: the per-channel
// debounce FSM encoding, default timing constants and the counter sizing helper.
package board_input_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } debounce_state_e;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;  // 10 ms at 50 MHz

    // Width of a counter that must hold values 0..debounce_cycles.
    function automatic int cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/board_input_conditioner_channel.sv
// One raw pad in, one clean level out: synchroniser chain followed by a
// stability counter that only accepts a new level after DEBOUNCE_CYCLES
// consecutive mismatching samples. oRise is high during the cycle whose
// closing edge commits a 0->1 change, so the caller can register an event
// on the same edge the level rises.
module debounce_channel
    import board_input_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic Clock,
    input  logic Reset,
    input  logic iRaw,
    output logic oLevel,
    output logic oRise
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    // Count value at which the next mismatching sample completes the window.
    localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    debounce_state_e        state_q, state_d;
    logic                   lvl_q, lvl_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   commit;

    assign s = sync_q[SYNC_STAGES-1];

    // State register: synchroniser shift, FSM state, accepted level and count.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values; blocking here would collapse the
        // synchroniser chain into a single stage.
        if (Reset) begin
            sync_q  <= '0;
            state_q <= STABLE;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], iRaw};
            state_q <= state_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: start, extend, abort or commit the stability window.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        state_d = state_q;
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (s != lvl_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        commit = 1'b1;
                    end else begin
                        state_d = CHECK;
                        cnt_d   = CW'(1);
                    end
                end
            end
            CHECK: begin
                if (s == lvl_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    commit  = 1'b1;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
        if (commit) begin
            lvl_d = s;
        end
    end

    // Outputs: registered level, and a rise strobe aligned with its commit edge.
    always_comb begin
        oLevel = lvl_q;
        oRise  = commit & s;
    end

endmodule

// File: rtl/board_input_conditioner.sv
// Conditions the board's buttons and switches for the SoC: one debounce
// channel per pad, plus sticky press-event flags for buttons that software
// clears with a per-bit acknowledge.
module board_input_conditioner
    import board_input_pkg::*;
#(
    parameter int N_BUTTONS       = 4,
    parameter int N_SWITCHES      = 2,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [N_BUTTONS-1:0]  iButtonRaw,
    input  logic [N_SWITCHES-1:0] iSwitchRaw,
    input  logic [N_BUTTONS-1:0]  iEventAck,
    output logic [N_BUTTONS-1:0]  oButton,
    output logic [N_SWITCHES-1:0] oSwitch,
    output logic [N_BUTTONS-1:0]  oPressEvent,
    output logic                  oEventPending
);

    logic [N_BUTTONS-1:0]  btn_rise;
    logic [N_SWITCHES-1:0] unused_sw_rise;  // switches carry no events
    logic [N_BUTTONS-1:0]  press_event_q;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_button
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .Clock  (Clock),
            .Reset  (Reset),
            .iRaw   (iButtonRaw[i]),
            .oLevel (oButton[i]),
            .oRise  (btn_rise[i])
        );
    end

    for (genvar i = 0; i < N_SWITCHES; i++) begin : g_switch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .Clock  (Clock),
            .Reset  (Reset),
            .iRaw   (iSwitchRaw[i]),
            .oLevel (oSwitch[i]),
            .oRise  (unused_sw_rise[i])
        );
    end

    // Sticky press flags: a new press wins over a same-cycle acknowledge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            press_event_q <= '0;
        end else begin
            press_event_q <= (press_event_q & ~iEventAck) | btn_rise;
        end
    end

    // Event outputs: the flags themselves and their combined pending flag.
    always_comb begin
        oPressEvent   = press_event_q;
        oEventPending = |press_event_q;
    end

endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed bench for board_input_conditioner: one instance with a 4-cycle
// debounce window and one with a single-cycle window, sharing clock and reset.
module tb_board_input_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] btn_raw = '0;
    logic [1:0] sw_raw  = '0;
    logic [3:0] ack     = '0;
    logic [3:0] btn;
    logic [1:0] sw;
    logic [3:0] ev;
    logic       pending;

    logic [3:0] b1_raw = '0;
    logic [1:0] s1_raw = '0;
    logic [3:0] ack1   = '0;
    logic [3:0] btn1;
    logic [1:0] sw1;
    logic [3:0] ev1;
    logic       pending1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    board_input_conditioner #(
        .N_BUTTONS       (4),
        .N_SWITCHES      (2),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .Clock         (clk),
        .Reset         (rst),
        .iButtonRaw    (btn_raw),
        .iSwitchRaw    (sw_raw),
        .iEventAck     (ack),
        .oButton       (btn),
        .oSwitch       (sw),
        .oPressEvent   (ev),
        .oEventPending (pending)
    );

    board_input_conditioner #(
        .N_BUTTONS       (4),
        .N_SWITCHES      (2),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (1)
    ) dut1 (
        .Clock         (clk),
        .Reset         (rst),
        .iButtonRaw    (b1_raw),
        .iSwitchRaw    (s1_raw),
        .iEventAck     (ack1),
        .oButton       (btn1),
        .oSwitch       (sw1),
        .oPressEvent   (ev1),
        .oEventPending (pending1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] hist;

        // Reset
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_button", 32'(btn), 32'(0));
        check("rst_switch", 32'(sw), 32'(0));
        check("rst_event", 32'(ev), 32'(0));
        check("rst_pending", 32'(pending), 32'(0));

        // 1. Clean press on button 0: commits at edge 6
        btn_raw[0] = 1'b1;
        repeat (5) tick();
        check("t1_btn0_edge5", 32'(btn[0]), 32'(0));
        check("t1_ev0_edge5", 32'(ev[0]), 32'(0));
        tick();
        check("t1_btn0_edge6", 32'(btn[0]), 32'(1));
        check("t1_ev0_edge6", 32'(ev[0]), 32'(1));
        check("t1_pending", 32'(pending), 32'(1));
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        check("t1_ev0_acked", 32'(ev[0]), 32'(0));
        check("t1_pending_acked", 32'(pending), 32'(0));
        check("t1_btn0_held", 32'(btn[0]), 32'(1));

        // 2. Bounce rejection on switch 1
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 4; k++) begin
                sw_raw[1] = (k != 3);
                tick();
                check("t2_bounce_sw1", 32'(sw[1]), 32'(0));
            end
        end
        sw_raw[1] = 1'b0;
        repeat (6) tick();
        check("t2_sw1_idle", 32'(sw[1]), 32'(0));
        sw_raw[1] = 1'b1;
        repeat (5) tick();
        check("t2_sw1_edge5", 32'(sw[1]), 32'(0));
        tick();
        check("t2_sw1_edge6", 32'(sw[1]), 32'(1));
        check("t2_no_switch_event", 32'(ev), 32'(0));

        // 3. Set/ack collision on button 2
        btn_raw[2] = 1'b1;
        repeat (5) tick();
        ack[2] = 1'b1;
        tick();
        ack[2] = 1'b0;
        check("t3_btn2_commit", 32'(btn[2]), 32'(1));
        check("t3_ev2_set_wins", 32'(ev[2]), 32'(1));
        ack[2] = 1'b1;
        tick();
        ack[2] = 1'b0;
        check("t3_ev2_second_ack", 32'(ev[2]), 32'(0));
        btn_raw[2] = 1'b0;
        repeat (8) tick();
        check("t3_btn2_released", 32'(btn[2]), 32'(0));
        check("t3_no_release_event", 32'(ev), 32'(0));
        check("t3_pending_low", 32'(pending), 32'(0));

        // 4. Reset in the middle of a check window on button 3
        btn_raw = '0;
        sw_raw  = '0;
        repeat (10) tick();
        check("t4_prep_buttons", 32'(btn), 32'(0));
        check("t4_prep_switches", 32'(sw), 32'(0));
        btn_raw[3] = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_in_reset_btn", 32'(btn), 32'(0));
        check("t4_in_reset_ev", 32'(ev), 32'(0));
        tick();
        check("t4_btn3_edge6", 32'(btn[3]), 32'(0));
        repeat (4) tick();
        check("t4_btn3_edge10", 32'(btn[3]), 32'(0));
        check("t4_ev3_edge10", 32'(ev[3]), 32'(0));
        tick();
        check("t4_btn3_edge11", 32'(btn[3]), 32'(1));
        check("t4_ev3_edge11", 32'(ev[3]), 32'(1));
        ack = 4'h8;
        tick();
        ack = '0;
        btn_raw = '0;
        repeat (10) tick();
        check("t4_cleanup_ev", 32'(ev), 32'(0));
        check("t4_cleanup_btn", 32'(btn), 32'(0));

        // 6. All four buttons at once, partial acknowledge
        btn_raw = 4'hF;
        repeat (5) tick();
        check("t6_ev_edge5", 32'(ev), 32'(0));
        tick();
        check("t6_btn_all", 32'(btn), 32'(4'hF));
        check("t6_ev_all", 32'(ev), 32'(4'hF));
        ack = 4'b0011;
        tick();
        ack = '0;
        check("t6_ev_partial", 32'(ev), 32'(4'hC));
        check("t6_pending_partial", 32'(pending), 32'(1));
        tick();
        check("t6_pending_hold", 32'(pending), 32'(1));
        ack = 4'b1100;
        tick();
        ack = '0;
        check("t6_ev_cleared", 32'(ev), 32'(0));
        check("t6_pending_cleared", 32'(pending), 32'(0));
        ack = 4'b0001;
        tick();
        ack = '0;
        check("t6_ack_on_clear", 32'(ev), 32'(0));

        // 5. Single-cycle debounce window: output follows 3 edges after drive
        for (int j = 0; j < 6; j++) begin
            s1_raw[0] = (j == 0);
            tick();
            if (j >= 2) begin
                check("t5_pulse_sw0", 32'(sw1[0]), 32'(j == 2));
            end
        end
        hist = '0;
        for (int j = 0; j < 12; j++) begin
            hist[j]   = (j % 2 == 1);
            s1_raw[0] = hist[j];
            b1_raw[1] = hist[j];
            tick();
            if (j >= 2) begin
                check("t5_alt_sw0", 32'(sw1[0]), 32'(hist[j-2]));
                check("t5_alt_btn1", 32'(btn1[1]), 32'(hist[j-2]));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
